fp_addsub_arbiter: RTL and testbench
====================================

Name: fp_addsub_arbiter

Overview:
- Shares one multi-cycle FP add/sub unit between two requesters: port 0 is the FADD/FSUB issue path and port 1 is the FP compare/convert helper path.
- Accepts requests over valid/ready and issues them one at a time through the unit's start/done interface.
- Holds operands stable while the unit is busy, captures the result on done and returns it to the originating requester over valid/ready.
- Sits between the FP issue stage and the add/sub datapath; the add/sub unit itself is unchanged.

Parameters:
- WIDTH, 32, operand/result width in bits (single-precision FP).
- TIMEOUT, 15, maximum cycles to wait for fu_done after fu_start before aborting.
- TO_W, 4, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk  in  1  clock, rising-edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  2  per-requester request valid.
- req_ready  out  2  per-requester request accepted (combinational from state and priority).
- req_a  in  2*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- req_b  in  2*WIDTH  operand B, same packing as req_a.
- req_sub  in  2  1 = subtract, 0 = add, per requester.
- rsp_valid  out  2  per-requester response valid.
- rsp_ready  in  2  per-requester response accepted.
- rsp_data  out  WIDTH  registered result, shared by both requesters.
- rsp_err  out  1  response produced by timeout; rsp_data is 0 in that case.
- fu_start  out  1  one-cycle start pulse to the add/sub unit.
- fu_a, fu_b  out  WIDTH  operands to the unit, held stable from fu_start until done.
- fu_sub  out  1  operation select to the unit.
- fu_done  in  1  one-cycle done pulse from the unit; result is valid in the same cycle.
- fu_result  in  WIDTH  result from the unit.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - state=IDLE, priority pointer=0, timeout counter=0.
  - All outputs 0: fu_start, rsp_valid, rsp_err, rsp_data, fu_a, fu_b, fu_sub, busy.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready is one-hot to the granted requester, or 0 if there are no requests.
  - Grant goes to the pointer's requester if it is valid, else to the other requester if valid.
  - On handshake (valid & ready): latch a/b/sub into the fu_* registers, record grant_id, go to ISSUE.
- ISSUE: fu_start=1 for exactly one cycle; clear the timeout counter; go to WAIT.
- WAIT:
  - Increment the counter each cycle.
  - On fu_done: capture fu_result into rsp_data, rsp_err=0, go to RESP.
  - Else, when the counter reaches TIMEOUT: rsp_data=0, rsp_err=1, go to RESP.
  - If fu_done and the timeout coincide, fu_done wins.
- RESP:
  - rsp_valid[grant_id]=1; rsp_data and rsp_err are held stable.
  - On rsp_ready[grant_id]: toggle the pointer to the other requester, go to IDLE.
  - rsp_ready on the non-granted bit is ignored.
- req_ready is 0 in ISSUE, WAIT and RESP: strictly one request in flight at a time.
- fu_done seen in IDLE, ISSUE or RESP is ignored. This covers a stale done from a unit that has no reset of its own.
- Latency with the existing 6-state unit and requester handshake in cycle 0:
  - fu_start in cycle 1; fu_done in cycle 7.
  - rsp_valid first asserted in cycle 8.
  - Earliest next acceptance in cycle 9 (one cycle after the rsp_ready handshake).
- Fairness: with both requesters valid continuously, grants alternate 0,1,0,1…
- Reset mid-operation: return to IDLE next cycle with fu_start=0; any in-flight result is dropped.
- fu_a/fu_b/fu_sub change only on an IDLE handshake.

Decomposition:
- Shared package fp_pkg holds:
  - The state encoding localparams (IDLE=2'b00, ISSUE=2'b01, WAIT=2'b10, RESP=2'b11).
  - FP_WIDTH=32 and the requester ID constants (REQ_ISSUE=0, REQ_AUX=1).
- One sub-module: rr_arbiter2, a combinational two-way round-robin grant from (valid[1:0], pointer) giving a one-hot grant.

Test Plan:
1. Single add on port 0: a=0x3F800000, b=0x40000000, sub=0; unit model returns 0x40400000 after 6 cycles → fu_start in cycle 1, rsp_valid[0] in cycle 8, rsp_data=0x40400000, rsp_err=0.
2. Simultaneous requests after reset, with port 1 doing sub on 0x40A00000 and 0x3F800000 → port 0 served first, then port 1 with rsp_data=0x40800000; req_ready[1]=0 until port 0's response handshake.
3. Both ports continuously valid for 6 transactions → grant order 0,1,0,1,0,1; exactly one fu_start per transaction.
4. Response backpressure: rsp_ready[0]=0 for 5 cycles → rsp_valid and rsp_data stable; no new fu_start; req_ready=0 throughout.
5. Unit never asserts done → after TIMEOUT=15 WAIT cycles, rsp_valid with rsp_err=1 and rsp_data=0; the next request proceeds normally.
6. reset asserted in WAIT, then a stale fu_done pulse 3 cycles later in IDLE → no rsp_valid; busy=0; the next request completes normally.

Source files
------------

// File: rtl/fp_pkg.sv
// -----------------------------------------------------------------------------
// fp_pkg
// Shared definitions for the FP add/sub arbiter:
//   - FSM state encoding (IDLE / ISSUE / WAIT / RESP)
//   - single-precision operand width
//   - requester identifiers for the two client paths
// -----------------------------------------------------------------------------
package fp_pkg;

    // Operand/result width for single-precision floating point.
    localparam int FP_WIDTH = 32;

    // Requester identifiers: port 0 is the FADD/FSUB issue path,
    // port 1 is the compare/convert helper path.
    localparam int REQ_ISSUE = 0;
    localparam int REQ_AUX   = 1;

    // State encoding, kept as plain constants so other blocks (or debug
    // logic) can decode the raw two-bit state value.
    localparam logic [1:0] ST_IDLE_ENC  = 2'b00;
    localparam logic [1:0] ST_ISSUE_ENC = 2'b01;
    localparam logic [1:0] ST_WAIT_ENC  = 2'b10;
    localparam logic [1:0] ST_RESP_ENC  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = ST_IDLE_ENC,
        ST_ISSUE = ST_ISSUE_ENC,
        ST_WAIT  = ST_WAIT_ENC,
        ST_RESP  = ST_RESP_ENC
    } arb_state_e;

    // Index of the requester that is not 'id'.
    function automatic logic other_req(input logic id);
        return ~id;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
// Combinational two-way round-robin grant.
//   valid[1:0] : request lines
//   ptr        : requester that currently holds priority
//   grant[1:0] : one-hot grant, all-zero when nothing is requesting
// The priority holder wins whenever it requests; otherwise the other
// requester wins if it requests.
// -----------------------------------------------------------------------------
module rr_arbiter2 (
    input  logic [1:0] valid,
    input  logic       ptr,
    output logic [1:0] grant
);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_grant
            // Requester gi wins if it asks and either holds priority or the
            // priority holder is not asking.
            assign grant[gi] = valid[gi] &&
                               ((ptr == 1'(gi)) || !valid[1 - gi]);
        end
    endgenerate

endmodule

// File: rtl/fp_addsub_arbiter.sv
// -----------------------------------------------------------------------------
// fp_addsub_arbiter
// Shares one multi-cycle FP add/sub unit between two requesters.
// A request is accepted over valid/ready, its operands are registered and
// held on fu_a/fu_b/fu_sub, the unit is started with a single-cycle pulse,
// and the result (or a timeout error) is returned to the originating
// requester over valid/ready. Only one request is in flight at a time.
//
// Ports
//   clk, reset            : rising-edge clock, synchronous active-high reset
//   req_valid/req_ready   : per-requester request handshake (2 bits)
//   req_a/req_b           : packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_sub               : per-requester op select (1 = subtract)
//   rsp_valid/rsp_ready   : per-requester response handshake (2 bits)
//   rsp_data, rsp_err     : shared registered result and timeout flag
//   fu_start, fu_a/b/sub  : start pulse and held operands to the unit
//   fu_done, fu_result    : completion pulse and result from the unit
//   busy                  : high whenever a request is in flight
// -----------------------------------------------------------------------------
module fp_addsub_arbiter
    import fp_pkg::*;
#(
    parameter int WIDTH   = FP_WIDTH,
    parameter int TIMEOUT = 15,
    parameter int TO_W    = 4       // 2**TO_W must exceed TIMEOUT
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [2*WIDTH-1:0]   req_a,
    input  logic [2*WIDTH-1:0]   req_b,
    input  logic [1:0]           req_sub,

    output logic [1:0]           rsp_valid,
    input  logic [1:0]           rsp_ready,
    output logic [WIDTH-1:0]     rsp_data,
    output logic                 rsp_err,

    output logic                 fu_start,
    output logic [WIDTH-1:0]     fu_a,
    output logic [WIDTH-1:0]     fu_b,
    output logic                 fu_sub,
    input  logic                 fu_done,
    input  logic [WIDTH-1:0]     fu_result,

    output logic                 busy
);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    arb_state_e         state_q,    state_d;
    logic               ptr_q,      ptr_d;
    logic               grant_id_q, grant_id_d;
    logic [TO_W-1:0]    to_cnt_q,   to_cnt_d;
    logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic               rsp_err_q,  rsp_err_d;
    logic [WIDTH-1:0]   fu_a_q,     fu_a_d;
    logic [WIDTH-1:0]   fu_b_q,     fu_b_d;
    logic               fu_sub_q,   fu_sub_d;

    // -------------------------------------------------------------------------
    // Request-side unpacking and arbitration
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] a_slice [2];
    logic [WIDTH-1:0] b_slice [2];
    logic [1:0]       grant;
    logic             grant_sel;
    logic             accept;
    logic [TO_W-1:0]  to_cnt_inc;
    logic             to_expired;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_unpack
            assign a_slice[gi] = req_a[gi*WIDTH +: WIDTH];
            assign b_slice[gi] = req_b[gi*WIDTH +: WIDTH];
        end
    endgenerate

    rr_arbiter2 u_rr (
        .valid (req_valid),
        .ptr   (ptr_q),
        .grant (grant)
    );

    // Ready is only offered while idle, so at most one request is in flight.
    assign req_ready = (state_q == ST_IDLE) ? grant : 2'b00;
    assign accept    = |req_ready;
    assign grant_sel = grant[1];

    // The counter is cleared in ISSUE, so after N WAIT cycles the
    // incremented value equals N; expiry therefore ends the TIMEOUT-th
    // WAIT cycle.
    assign to_cnt_inc = to_cnt_q + TO_W'(1);
    assign to_expired = (to_cnt_inc == TO_W'(TIMEOUT));

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_id_d = grant_id_q;
        to_cnt_d   = to_cnt_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        fu_a_d     = fu_a_q;
        fu_b_d     = fu_b_q;
        fu_sub_d   = fu_sub_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    fu_a_d     = a_slice[grant_sel];
                    fu_b_d     = b_slice[grant_sel];
                    fu_sub_d   = req_sub[grant_sel];
                    grant_id_d = grant_sel;
                    state_d    = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                to_cnt_d = '0;
                state_d  = ST_WAIT;
            end

            ST_WAIT: begin
                to_cnt_d = to_cnt_inc;
                // A done pulse takes precedence over a coincident expiry.
                if (fu_done) begin
                    rsp_data_d = fu_result;
                    rsp_err_d  = 1'b0;
                    state_d    = ST_RESP;
                end else if (to_expired) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    state_d    = ST_RESP;
                end
            end

            ST_RESP: begin
                // Only the owner's ready bit completes the response.
                if (rsp_ready[grant_id_q]) begin
                    ptr_d   = other_req(grant_id_q);
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ptr_q      <= 1'b0;
            grant_id_q <= 1'b0;
            to_cnt_q   <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            fu_a_q     <= '0;
            fu_b_q     <= '0;
            fu_sub_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_id_q <= grant_id_d;
            to_cnt_q   <= to_cnt_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            fu_a_q     <= fu_a_d;
            fu_b_q     <= fu_b_d;
            fu_sub_q   <= fu_sub_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rsp_valid
            assign rsp_valid[gi] = (state_q == ST_RESP) &&
                                   (grant_id_q == 1'(gi));
        end
    endgenerate

    assign fu_start = (state_q == ST_ISSUE);
    assign busy     = (state_q != ST_IDLE);
    assign rsp_data = rsp_data_q;
    assign rsp_err  = rsp_err_q;
    assign fu_a     = fu_a_q;
    assign fu_b     = fu_b_q;
    assign fu_sub   = fu_sub_q;

endmodule

// File: tb/tb_fp_addsub_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fp_addsub_arbiter
// Drives two requesters, models the add/sub unit (arithmetic done on reals),
// and checks responses against a scoreboard of expected results built when
// each request is accepted.
// -----------------------------------------------------------------------------
module tb_fp_addsub_arbiter;

    localparam int W       = 32;
    localparam int TIMEOUT = 15;

    logic           clk = 1'b0;
    logic           reset;
    logic [1:0]     req_valid, req_ready, req_sub;
    logic [2*W-1:0] req_a, req_b;
    logic [1:0]     rsp_valid, rsp_ready;
    logic [W-1:0]   rsp_data;
    logic           rsp_err;
    logic           fu_start, fu_sub, fu_done, busy;
    logic [W-1:0]   fu_a, fu_b, fu_result;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    fp_addsub_arbiter #(.WIDTH(W), .TIMEOUT(TIMEOUT), .TO_W(4)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_sub(req_sub),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .fu_start(fu_start), .fu_a(fu_a), .fu_b(fu_b), .fu_sub(fu_sub),
        .fu_done(fu_done), .fu_result(fu_result),
        .busy(busy)
    );

    // ---------------------------------------------------------------- helpers
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic real sp2real(input logic [31:0] x);
        real m;
        int  e;
        if (x[30:0] == 31'd0) return 0.0;
        m = 1.0 + real'(x[22:0]) / 8388608.0;
        e = int'(x[30:23]) - 127;
        while (e > 0) begin m = m * 2.0; e--; end
        while (e < 0) begin m = m / 2.0; e++; end
        return x[31] ? -m : m;
    endfunction

    function automatic logic [31:0] real2sp(input real r);
        logic [63:0] d;
        if (r == 0.0) return 32'd0;
        d = $realtobits(r);
        return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
    endfunction

    function automatic logic [31:0] fp_op(input logic [31:0] a, input logic [31:0] b, input logic sub);
        real r;
        r = sub ? (sp2real(a) - sp2real(b)) : (sp2real(a) + sp2real(b));
        return real2sp(r);
    endfunction

    function automatic logic [1:0] exp_grant(input logic [1:0] v, input int p);
        if (v[p])     return 2'(1 << p);
        if (v[1 - p]) return 2'(1 << (1 - p));
        return 2'b00;
    endfunction

    // ---------------------------------------------------------------- stimulus
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        int          lat;    // unit latency; 0 = unit never answers
    } stim_t;

    typedef struct {
        int          port;
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] data;
        logic        err;
        int          rsp_lat;
        int          acc_cyc;
    } exp_t;

    stim_t stim_q0[$];
    stim_t stim_q1[$];
    int    cur_lat [2];
    logic  hs_pend [2];
    logic  rr_rand = 1'b0;
    logic [1:0] rr_force = 2'b11;

    // Requester and response-ready driver: inputs change only on negedge.
    initial begin
        stim_t s;
        logic  have;
        req_valid = 2'b00; req_a = '0; req_b = '0; req_sub = 2'b00;
        rsp_ready = 2'b11;
        hs_pend[0] = 1'b0; hs_pend[1] = 1'b0;
        cur_lat[0] = 6; cur_lat[1] = 6;
        forever begin
            @(negedge clk);
            rsp_ready = rr_rand ? 2'($urandom) : rr_force;
            for (int i = 0; i < 2; i++) begin
                if (hs_pend[i]) begin
                    req_valid[i] = 1'b0;
                    hs_pend[i]   = 1'b0;
                end
                have = 1'b0;
                if (!req_valid[i] && !reset) begin
                    if (i == 0 && stim_q0.size() > 0) begin s = stim_q0.pop_front(); have = 1'b1; end
                    if (i == 1 && stim_q1.size() > 0) begin s = stim_q1.pop_front(); have = 1'b1; end
                end
                if (have) begin
                    req_valid[i]      = 1'b1;
                    req_a[i*W +: W]   = s.a;
                    req_b[i*W +: W]   = s.b;
                    req_sub[i]        = s.sub;
                    cur_lat[i]        = s.lat;
                end
            end
            #1;
            for (int i = 0; i < 2; i++)
                if (req_valid[i] && req_ready[i]) hs_pend[i] = 1'b1;
        end
    end

    // ---------------------------------------------------------------- unit model
    // Behaves like a unit without reset: a pending done still fires after reset.
    int          cur_fu_lat = 6;
    int          fu_cnt = 0;
    logic [31:0] fu_hold;
    initial begin
        fu_done = 1'b0; fu_result = 32'h0;
        forever begin
            @(negedge clk);
            fu_done   = 1'b0;
            fu_result = $urandom;
            if (fu_cnt > 0) begin
                fu_cnt--;
                if (fu_cnt == 0) begin
                    fu_done   = 1'b1;
                    fu_result = fu_hold;
                end
            end
            if (fu_start) begin
                fu_cnt  = cur_fu_lat;
                fu_hold = fp_op(fu_a, fu_b, fu_sub);
            end
        end
    end

    // ---------------------------------------------------------------- monitor
    exp_t        sb_q[$];
    logic        inflight = 1'b0;
    int          ptr_m = 0;
    logic        rsp_seen = 1'b0;
    logic [31:0] hold_data;
    logic        hold_err;
    int          start_cnt = 0;
    int          n_done = 0;
    int          served_q[$];
    logic [31:0] last_data [2];
    logic        last_err  [2];

    initial begin
        exp_t       e;
        logic [1:0] hs;
        forever begin
            @(negedge clk);
            #2;
            if (reset) begin
                sb_q.delete();
                inflight  = 1'b0;
                ptr_m     = 0;
                rsp_seen  = 1'b0;
                start_cnt = 0;
            end else begin
                chk("busy", 64'(busy), 64'(inflight));
                chk("req_ready", 64'(req_ready),
                    64'(inflight ? 2'b00 : exp_grant(req_valid, ptr_m)));

                if (fu_start) begin
                    start_cnt++;
                    chk("fu_start_inflight", 64'(inflight), 64'd1);
                    if (sb_q.size() > 0)
                        chk("start_latency", 64'(cyc - sb_q[0].acc_cyc), 64'd1);
                end

                hs = req_valid & req_ready;
                if (hs != 2'b00 && !inflight) begin
                    e.port    = hs[1] ? 1 : 0;
                    e.a       = req_a[e.port*W +: W];
                    e.b       = req_b[e.port*W +: W];
                    e.sub     = req_sub[e.port];
                    e.acc_cyc = cyc;
                    cur_fu_lat = cur_lat[e.port];
                    if (cur_lat[e.port] >= 1 && cur_lat[e.port] <= TIMEOUT) begin
                        e.data    = fp_op(e.a, e.b, e.sub);
                        e.err     = 1'b0;
                        e.rsp_lat = cur_lat[e.port] + 2;
                    end else begin
                        e.data    = 32'd0;
                        e.err     = 1'b1;
                        e.rsp_lat = TIMEOUT + 2;
                    end
                    sb_q.push_back(e);
                    served_q.push_back(e.port);
                    inflight  = 1'b1;
                    start_cnt = 0;
                end

                if (rsp_valid != 2'b00) begin
                    if (sb_q.size() == 0) begin
                        chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
                    end else begin
                        e = sb_q[0];
                        if (!rsp_seen) begin
                            chk("rsp_valid_port", 64'(rsp_valid), 64'(1 << e.port));
                            chk("rsp_data", 64'(rsp_data), 64'(e.data));
                            chk("rsp_err", 64'(rsp_err), 64'(e.err));
                            chk("rsp_latency", 64'(cyc - e.acc_cyc), 64'(e.rsp_lat));
                            chk("fu_start_count", 64'(start_cnt), 64'd1);
                            chk("fu_a", 64'(fu_a), 64'(e.a));
                            chk("fu_b", 64'(fu_b), 64'(e.b));
                            chk("fu_sub", 64'(fu_sub), 64'(e.sub));
                            rsp_seen  = 1'b1;
                            hold_data = rsp_data;
                            hold_err  = rsp_err;
                            last_data[e.port] = rsp_data;
                            last_err[e.port]  = rsp_err;
                        end else begin
                            chk("rsp_hold_data", 64'(rsp_data), 64'(hold_data));
                            chk("rsp_hold_err", 64'(rsp_err), 64'(hold_err));
                            chk("rsp_hold_valid", 64'(rsp_valid), 64'(1 << e.port));
                            chk("no_restart", 64'(start_cnt), 64'd1);
                        end
                        if (rsp_ready[e.port]) begin
                            void'(sb_q.pop_front());
                            inflight = 1'b0;
                            ptr_m    = 1 - e.port;
                            rsp_seen = 1'b0;
                            n_done++;
                        end
                    end
                end else if (rsp_seen) begin
                    chk("rsp_dropped", 64'(rsp_valid), 64'(1 << sb_q[0].port));
                end
            end
        end
    end

    // ---------------------------------------------------------------- main
    int n_exp_done = 0;

    task automatic wait_idle(input int budget);
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < budget && !ok; k++) begin
            @(negedge clk);
            #3;
            if (stim_q0.size() == 0 && stim_q1.size() == 0 && req_valid == 2'b00 &&
                !inflight && !hs_pend[0] && !hs_pend[1])
                ok = 1'b1;
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_idle: still busy after %0d cycles, required idle", budget);
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        reset = 1'b1;
        repeat (n) @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic stim_t mk(input logic [31:0] a, input logic [31:0] b,
                                 input logic sub, input int lat);
        stim_t s;
        s.a = a; s.b = b; s.sub = sub; s.lat = lat;
        return s;
    endfunction

    function automatic logic [31:0] rnd_fp();
        return real2sp(real'($urandom_range(1, 4096)));
    endfunction

    initial begin
        int   wd;
        logic seen;
        reset = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        #3;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_fu_start", 64'(fu_start), 64'd0);
        chk("reset_rsp_data", 64'(rsp_data), 64'd0);
        chk("reset_rsp_err", 64'(rsp_err), 64'd0);
        chk("reset_fu_a", 64'(fu_a), 64'd0);
        chk("reset_fu_b", 64'(fu_b), 64'd0);
        chk("reset_fu_sub", 64'(fu_sub), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // 1: single add on port 0
        stim_q0.push_back(mk(32'h3F800000, 32'h40000000, 1'b0, 6));
        n_exp_done++;
        wait_idle(200);
        chk("t1_data", 64'(last_data[0]), 64'h40400000);
        chk("t1_err", 64'(last_err[0]), 64'd0);

        // 2: simultaneous requests straight after reset
        do_reset(1);
        #3;
        served_q.delete();
        stim_q0.push_back(mk(32'h40400000, 32'h3F800000, 1'b0, 6));
        stim_q1.push_back(mk(32'h40A00000, 32'h3F800000, 1'b1, 6));
        n_exp_done += 2;
        wait_idle(200);
        chk("t2_count", 64'(served_q.size()), 64'd2);
        if (served_q.size() == 2) begin
            chk("t2_first", 64'(served_q[0]), 64'd0);
            chk("t2_second", 64'(served_q[1]), 64'd1);
        end
        chk("t2_data1", 64'(last_data[1]), 64'h40800000);

        // 3: both continuously valid -> alternating grants
        served_q.delete();
        for (int k = 0; k < 3; k++) begin
            stim_q0.push_back(mk(rnd_fp(), rnd_fp(), 1'($urandom), int'($urandom_range(1, 8))));
            stim_q1.push_back(mk(rnd_fp(), rnd_fp(), 1'($urandom), int'($urandom_range(1, 8))));
        end
        n_exp_done += 6;
        wait_idle(500);
        chk("t3_count", 64'(served_q.size()), 64'd6);
        for (int k = 0; k < served_q.size(); k++)
            chk("t3_order", 64'(served_q[k]), 64'(k % 2));

        // 4: response backpressure on port 0, port 1 waiting
        rr_force = 2'b10;
        stim_q0.push_back(mk(rnd_fp(), rnd_fp(), 1'b0, 4));
        stim_q1.push_back(mk(rnd_fp(), rnd_fp(), 1'b1, 3));
        n_exp_done += 2;
        seen = 1'b0;
        for (wd = 0; wd < 100 && !seen; wd++) begin
            @(negedge clk);
            #3;
            seen = rsp_valid[0];
        end
        chk("t4_rsp_seen", 64'(seen), 64'd1);
        repeat (5) begin
            @(negedge clk);
            #3;
            chk("t4_hold_valid", 64'(rsp_valid), 64'b01);
            chk("t4_no_ready", 64'(req_ready), 64'd0);
        end
        rr_force = 2'b11;
        wait_idle(200);

        // 5: unit never answers -> timeout, then normal request
        stim_q0.push_back(mk(rnd_fp(), rnd_fp(), 1'b0, 0));
        n_exp_done++;
        wait_idle(200);
        chk("t5_err", 64'(last_err[0]), 64'd1);
        chk("t5_data", 64'(last_data[0]), 64'd0);
        stim_q1.push_back(mk(32'h40A00000, 32'h40000000, 1'b0, 5));
        n_exp_done++;
        wait_idle(200);
        chk("t5_next_err", 64'(last_err[1]), 64'd0);
        chk("t5_next_data", 64'(last_data[1]), 64'h40E00000);

        // 6: reset during WAIT, stale done arrives afterwards in IDLE
        stim_q1.push_back(mk(rnd_fp(), rnd_fp(), 1'b1, 6));
        seen = 1'b0;
        for (wd = 0; wd < 50 && !seen; wd++) begin
            @(negedge clk);
            #3;
            seen = fu_start;
        end
        chk("t6_started", 64'(seen), 64'd1);
        repeat (1) @(negedge clk);
        do_reset(1);
        #3;
        chk("t6_busy", 64'(busy), 64'd0);
        chk("t6_fu_start", 64'(fu_start), 64'd0);
        chk("t6_fu_a", 64'(fu_a), 64'd0);
        seen = 1'b0;
        for (wd = 0; wd < 20 && !seen; wd++) begin
            @(negedge clk);
            #3;
            seen = fu_done;
        end
        chk("t6_stale_done", 64'(seen), 64'd1);
        chk("t6_stale_busy", 64'(busy), 64'd0);
        chk("t6_stale_rsp", 64'(rsp_valid), 64'd0);
        repeat (3) begin
            @(negedge clk);
            #3;
            chk("t6_quiet", 64'(rsp_valid), 64'd0);
        end
        stim_q0.push_back(mk(32'h40000000, 32'h40000000, 1'b0, 6));
        n_exp_done++;
        wait_idle(200);
        chk("t6_next_data", 64'(last_data[0]), 64'h40800000);

        // Random traffic with random response backpressure and latencies,
        // including the done/timeout coincidence and occasional no-answer.
        rr_rand = 1'b1;
        for (int k = 0; k < 30; k++) begin
            stim_t s;
            s = mk(rnd_fp(), rnd_fp(), 1'($urandom),
                   ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 16)));
            if ($urandom_range(0, 1) == 0) stim_q0.push_back(s);
            else                           stim_q1.push_back(s);
            n_exp_done++;
            repeat ($urandom_range(0, 12)) @(negedge clk);
        end
        wait_idle(3000);
        rr_rand  = 1'b0;
        rr_force = 2'b11;

        chk("all_completed", 64'(n_done), 64'(n_exp_done));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
